fb_branch_resolve: RTL and testbench
====================================

# fb_branch_resolve

Branch resolution unit that consumes the ALU condition flags `{NF, ZF, CF, VF}` written by compare operations and turns branch requests into PC redirects. It sits in EX beside the ALU. It holds the architectural flag register, waits for fresh flags when a branch arrives ahead of its compare, evaluates the RV32I branch condition from `funct3`, and drives a registered redirect/flush to IF/ID.

## Interface
Parameters:
- `FLUSH_CYCLES`, default 2: cycles `flush` is held after a taken branch (1..7).
- `WAIT_MAX`, default 15: maximum cycles spent in WAIT_FLAGS before timeout (1..255).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `csr_in` in 4: flags from ALU, `{NF, ZF, CF, VF}`.
- `csr_write` in 1: `csr_in` valid this cycle.
- `br_valid` in 1: branch request valid.
- `br_ready` out 1: unit can accept a branch.
- `br_funct3` in 3: branch type.
- `br_pc` in 32: branch instruction PC.
- `br_offset` in 32: sign-extended B-immediate.
- `redirect_valid` out 1: one-cycle pulse, branch taken.
- `redirect_pc` out 32: taken target.
- `flush` out 1: squash younger instructions.
- `br_illegal` out 1: one-cycle pulse, `funct3` is 010 or 011.
- `br_timeout` out 1: one-cycle pulse, WAIT_MAX exceeded.
- `flags` out 4: architectural flag register.

## Operation
- Flag register: `flags <= csr_in` on every `csr_write`. `flags_valid` is set by `csr_write` and cleared when a branch consumes the flags. If a consume and a `csr_write` happen in the same cycle, the write wins and `flags_valid` is 1 (except in the bypass case, see Configuration).
- Handshake: a branch is accepted when `br_valid && br_ready`. `br_ready` = (state == IDLE). On accept, the unit captures `funct3` and `target = (br_pc + br_offset) mod 2^32` with bit 0 forced to 0.
- Conditions:
  - 000 BEQ: ZF
  - 001 BNE: !ZF
  - 100 BLT: NF != VF
  - 101 BGE: NF == VF
  - 110 BLTU: !CF
  - 111 BGEU: CF
- Illegal `funct3` (010, 011): accepted, `br_illegal` pulses, the branch is not taken, flags are not consumed, and the unit returns to IDLE.
- States:
  - IDLE: on accept, if flags are available, resolve immediately and go to FLUSH if taken, else stay in IDLE. If flags are not available, go to WAIT_FLAGS and clear the wait counter.
  - WAIT_FLAGS: resolve as soon as flags are available (taken -> FLUSH, not taken -> IDLE). Otherwise increment the counter. When the counter reaches WAIT_MAX, pulse `br_timeout`, go to IDLE, no redirect.
  - FLUSH: hold `flush` for FLUSH_CYCLES cycles, then go to IDLE.
- Reset values:
  - state IDLE
  - `flags` = 0000, `flags_valid` = 0
  - `redirect_valid`, `flush`, `br_illegal`, `br_timeout` = 0
  - `redirect_pc` = 0
  - `br_ready` = 1 (after reset deasserts)
- Reset mid-operation: all state and outputs return to reset values immediately; a pending branch is dropped.

## Timing
- All outputs are registered except `br_ready`, which is decoded from the state register.
- Resolution in cycle T produces the following in cycle T+1:
  - `redirect_valid` and `redirect_pc` for exactly one cycle (taken only).
  - `flush` high from T+1 through T+FLUSH_CYCLES.
  - `br_ready` low for those same cycles.
- A not-taken resolution at T gives `br_ready` = 1 at T+1, so branches can be accepted back-to-back.
- WAIT_FLAGS without bypass: `csr_write` at T sets `flags_valid`, and resolution happens at T+1 (redirect at T+2).

## Configuration
- `FB_FLAG_BYPASS_EN` defined:
  - A `csr_write` in the same cycle as accept, or in the same cycle as a WAIT_FLAGS evaluation, counts as "flags available", and `csr_in` is used directly.
  - This saves one cycle.
  - The write is consumed, so `flags_valid` ends at 0; `flags` still latches `csr_in`.
- Undefined:
  - Only the registered `flags` / `flags_valid` are used.
  - A same-cycle `csr_write` is latched and sets `flags_valid`; it does not resolve the branch in that cycle.

## Test plan
- Reset: `rst` asserted mid-FLUSH -> `flush` = 0, `redirect_valid` = 0, `flags` = 0000, `br_ready` = 1 after release.
- `csr_write` `{0,1,0,0}`, then BEQ with `br_pc` = 0x100, `br_offset` = 0x20 -> `redirect_valid` pulse with `redirect_pc` = 0x120, `flush` high for 2 cycles, `br_ready` low for 2 cycles.
- `flags` `{1,0,1,0}`, BLT then BGEU:
  - BLT taken.
  - BGEU issued with no new write -> waits in WAIT_FLAGS.
  - `csr_write` `{0,0,1,0}` -> BGEU taken one cycle later (or in the same cycle with bypass).
- BNE with no `csr_write` for 15 cycles -> `br_timeout` pulses once, no redirect, `br_ready` = 1.
- `funct3` = 010 with flags valid -> `br_illegal` pulse, no `flush`, `flags_valid` still 1.
- Not-taken BNE (ZF=1), followed by a new write and a BEQ at 0xFFFFFFF0 with offset 0x14 -> target wraps to 0x00000004.

Source files
------------

// File: rtl/fb_branch_resolve.sv
// fb_branch_resolve: EX-stage branch resolution against the architectural {N,Z,C,V} flag register.
// Optional build macro FB_FLAG_BYPASS_EN lets a same-cycle csr_write resolve a branch directly.
module fb_branch_resolve #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned WAIT_MAX     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  csr_in,
  input  logic        csr_write,
  input  logic        br_valid,
  output logic        br_ready,
  input  logic [2:0]  br_funct3,
  input  logic [31:0] br_pc,
  input  logic [31:0] br_offset,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        flush,
  output logic        br_illegal,
  output logic        br_timeout,
  output logic [3:0]  flags
);

  // state      | meaning
  // IDLE       | ready; resolves at accept when flags are available
  // WAIT_FLAGS | branch held until flags arrive or the wait timer expires
  // FLUSH      | taken branch, flush held for FLUSH_CYCLES cycles
  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FLAGS = 2'd1,
    FLUSH      = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LOAD  = 8'(WAIT_MAX - 1);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  flags_q, flags_d;
  logic        flags_valid_q, flags_valid_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] target_q, target_d;
  logic [7:0]  wait_cnt_q, wait_cnt_d;
  logic [2:0]  flush_cnt_q, flush_cnt_d;
  logic        redirect_valid_q, redirect_valid_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        flush_q, flush_d;
  logic        illegal_q, illegal_d;
  logic        timeout_q, timeout_d;

  logic        flags_avail;
  logic [3:0]  eval_flags;
  logic        bypass_used;
  logic        illegal_in;
  logic [31:0] sum_in;
  logic [31:0] target_in;
  logic        resolve;
  logic [2:0]  res_f3;
  logic [31:0] res_target;

  function automatic logic cond_met(input logic [2:0] f3, input logic [3:0] fl);
    logic n, z, c, v;
    {n, z, c, v} = fl;
    case (f3)
      3'b000:  return z;
      3'b001:  return !z;
      3'b100:  return n != v;
      3'b101:  return n == v;
      3'b110:  return !c;
      3'b111:  return c;
      default: return 1'b0;
    endcase
  endfunction

`ifdef FB_FLAG_BYPASS_EN
  assign flags_avail = flags_valid_q | csr_write;
  assign eval_flags  = csr_write ? csr_in : flags_q;
  assign bypass_used = csr_write;
`else
  assign flags_avail = flags_valid_q;
  assign eval_flags  = flags_q;
  assign bypass_used = 1'b0;
`endif

  assign illegal_in = (br_funct3[2:1] == 2'b01);
  assign sum_in     = br_pc + br_offset;
  assign target_in  = {sum_in[31:1], 1'b0};

  always_comb begin
    state_d          = state_q;
    flags_d          = flags_q;
    flags_valid_d    = flags_valid_q;
    funct3_d         = funct3_q;
    target_d         = target_q;
    wait_cnt_d       = wait_cnt_q;
    flush_cnt_d      = flush_cnt_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = 1'b0;
    illegal_d        = 1'b0;
    timeout_d        = 1'b0;
    resolve          = 1'b0;
    res_f3           = funct3_q;
    res_target       = target_q;

    case (state_q)
      IDLE: begin
        if (br_valid) begin
          funct3_d = br_funct3;
          target_d = target_in;
          if (illegal_in) begin
            illegal_d = 1'b1;
          end else if (flags_avail) begin
            resolve    = 1'b1;
            res_f3     = br_funct3;
            res_target = target_in;
          end else begin
            state_d    = WAIT_FLAGS;
            wait_cnt_d = WAIT_LOAD;
          end
        end
      end
      WAIT_FLAGS: begin
        if (flags_avail) begin
          resolve = 1'b1;
        end else if (wait_cnt_q == 8'd0) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q - 8'd1;
        end
      end
      FLUSH: begin
        if (flush_cnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          flush_d     = 1'b1;
          flush_cnt_d = flush_cnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (resolve) begin
      if (cond_met(res_f3, eval_flags)) begin
        redirect_valid_d = 1'b1;
        redirect_pc_d    = res_target;
        flush_d          = 1'b1;
        flush_cnt_d      = FLUSH_LOAD;
        state_d          = FLUSH;
      end else begin
        state_d = IDLE;
      end
    end

    // A write normally outlives a same-cycle consume, unless the write itself was consumed.
    if (csr_write) flags_d = csr_in;
    if (csr_write && !(resolve && bypass_used)) flags_valid_d = 1'b1;
    else if (resolve)                            flags_valid_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      flags_q          <= 4'b0000;
      flags_valid_q    <= 1'b0;
      funct3_q         <= 3'b000;
      target_q         <= 32'h0;
      wait_cnt_q       <= 8'd0;
      flush_cnt_q      <= 3'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'h0;
      flush_q          <= 1'b0;
      illegal_q        <= 1'b0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      flags_q          <= flags_d;
      flags_valid_q    <= flags_valid_d;
      funct3_q         <= funct3_d;
      target_q         <= target_d;
      wait_cnt_q       <= wait_cnt_d;
      flush_cnt_q      <= flush_cnt_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      illegal_q        <= illegal_d;
      timeout_q        <= timeout_d;
    end
  end

  assign br_ready       = (state_q == IDLE);
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign br_illegal     = illegal_q;
  assign br_timeout     = timeout_q;
  assign flags          = flags_q;

endmodule

// File: tb/tb_fb_branch_resolve.sv
// Self-checking bench for fb_branch_resolve: directed scenarios plus randomized branches
// against a transaction-level model of flag availability, latency and branch outcome.
module tb_fb_branch_resolve;
  localparam int FC = 2;
  localparam int WM = 15;
`ifdef FB_FLAG_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  csr_in;
  logic        csr_write;
  logic        br_valid;
  logic        br_ready;
  logic [2:0]  br_funct3;
  logic [31:0] br_pc;
  logic [31:0] br_offset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        flush;
  logic        br_illegal;
  logic        br_timeout;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;
  logic [3:0] m_flags;
  bit         m_fv;

  always #5 clk = ~clk;

  fb_branch_resolve #(.FLUSH_CYCLES(FC), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst), .csr_in(csr_in), .csr_write(csr_write),
    .br_valid(br_valid), .br_ready(br_ready), .br_funct3(br_funct3),
    .br_pc(br_pc), .br_offset(br_offset), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .br_illegal(br_illegal),
    .br_timeout(br_timeout), .flags(flags)
  );

  // Flags describe a compare a-b: Z means equal, N^V means signed less, !C means unsigned less.
  function automatic bit exp_taken(input logic [2:0] f3, input logic [3:0] fl);
    bit eq, lt, ltu;
    eq  = fl[2];
    lt  = fl[3] ^ fl[0];
    ltu = !fl[1];
    case (f3)
      3'd0: return eq;
      3'd1: return !eq;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic write_flags(input logic [3:0] v);
    csr_in = v; csr_write = 1'b1;
    cyc();
    csr_write = 1'b0;
    m_flags = v; m_fv = 1'b1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] off);
    br_valid = 1'b1; br_funct3 = f3; br_pc = pc; br_offset = off;
    cyc();
    br_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; csr_in = 4'h0; csr_write = 1'b0; br_valid = 1'b0;
    br_funct3 = 3'd0; br_pc = 32'h0; br_offset = 32'h0;
    repeat (2) cyc();
    checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL rst_redirect_valid: got %b exp 0", redirect_valid); end
    checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL rst_redirect_pc: got %h exp 0", redirect_pc); end
    checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush: got %b exp 0", flush); end
    checks++; if (flags !== 4'h0) begin errors++; $display("FAIL rst_flags: got %b exp 0000", flags); end
    checks++; if ({br_illegal, br_timeout} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b exp 00", {br_illegal, br_timeout}); end
    rst = 1'b0;
    cyc();
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", br_ready); end
    m_flags = 4'h0; m_fv = 1'b0;
  endtask

  task automatic test_beq_taken();
    write_flags(4'b0100);
    checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL beq_flags: got %b exp 0100", flags); end
    issue(3'd0, 32'h100, 32'h20);
    m_fv = 1'b0;
    checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL beq_redirect: got %b exp 1", redirect_valid); end
    checks++; if (redirect_pc !== 32'h120) begin errors++; $display("FAIL beq_pc: got %h exp 00000120", redirect_pc); end
    checks++; if ({flush, br_ready} !== 2'b10) begin errors++; $display("FAIL beq_flush1: got flush/ready %b exp 10", {flush, br_ready}); end
    cyc();
    checks++; if ({redirect_valid, flush, br_ready} !== 3'b010) begin errors++; $display("FAIL beq_flush2: got rv/flush/ready %b exp 010", {redirect_valid, flush, br_ready}); end
    cyc();
    checks++; if ({flush, br_ready} !== 2'b01) begin errors++; $display("FAIL beq_flush_end: got flush/ready %b exp 01", {flush, br_ready}); end
  endtask

  task automatic test_blt_bgeu_wait();
    write_flags(4'b1010);
    issue(3'd4, 32'h300, 32'h40);
    m_fv = 1'b0;
    checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h340}) begin errors++; $display("FAIL blt_taken: got %b %h exp 1 00000340", redirect_valid, redirect_pc); end
    repeat (FC) cyc();
    issue(3'd7, 32'h200, 32'hFFFF_FFF8);
    checks++; if ({br_ready, redirect_valid} !== 2'b00) begin errors++; $display("FAIL bgeu_wait: got ready/rv %b exp 00", {br_ready, redirect_valid}); end
    cyc();
    write_flags(4'b0010);
    m_fv = 1'b0;
    if (!BYPASS) begin
      checks++; if ({br_ready, redirect_valid} !== 2'b00) begin errors++; $display("FAIL bgeu_latch: got ready/rv %b exp 00", {br_ready, redirect_valid}); end
      cyc();
    end
    checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h1F8}) begin errors++; $display("FAIL bgeu_taken: got %b %h exp 1 000001f8", redirect_valid, redirect_pc); end
    repeat (FC) cyc();
  endtask

  task automatic test_timeout();
    int tcount = 0, tj = 0, rcount = 0;
    issue(3'd1, 32'h400, 32'h8);
    for (int j = 1; j <= WM + 8; j++) begin
      cyc();
      if (br_timeout === 1'b1) begin tcount++; tj = j; end
      if (redirect_valid !== 1'b0) rcount++;
    end
    checks++; if (tcount != 1) begin errors++; $display("FAIL timeout_count: got %0d exp 1", tcount); end
    checks++; if (tj != WM) begin errors++; $display("FAIL timeout_cycle: got %0d exp %0d", tj, WM); end
    checks++; if (rcount != 0) begin errors++; $display("FAIL timeout_redirect: got %0d redirects exp 0", rcount); end
    checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL timeout_ready: got %b exp 1", br_ready); end
  endtask

  task automatic test_illegal();
    write_flags(4'b0100);
    issue(3'b010, 32'h40, 32'h10);
    checks++; if ({br_illegal, flush, redirect_valid, br_ready} !== 4'b1001) begin errors++; $display("FAIL illegal_pulse: got ill/flush/rv/ready %b exp 1001", {br_illegal, flush, redirect_valid, br_ready}); end
    issue(3'd0, 32'h40, 32'h10);
    m_fv = 1'b0;
    checks++; if ({br_illegal, redirect_valid, redirect_pc} !== {2'b01, 32'h50}) begin errors++; $display("FAIL illegal_keeps_flags: got ill %b rv %b pc %h exp 0 1 00000050", br_illegal, redirect_valid, redirect_pc); end
    repeat (FC) cyc();
  endtask

  task automatic test_wrap();
    write_flags(4'b0100);
    issue(3'd1, 32'h80, 32'h4);
    m_fv = 1'b0;
    checks++; if ({redirect_valid, flush, br_ready} !== 3'b001) begin errors++; $display("FAIL bne_not_taken: got rv/flush/ready %b exp 001", {redirect_valid, flush, br_ready}); end
    write_flags(4'b0100);
    issue(3'd0, 32'hFFFF_FFF0, 32'h14);
    m_fv = 1'b0;
    checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h4}) begin errors++; $display("FAIL wrap_target: got %b %h exp 1 00000004", redirect_valid, redirect_pc); end
    repeat (FC) cyc();
  endtask

  task automatic test_reset_mid_flush();
    write_flags(4'b0100);
    issue(3'd0, 32'h500, 32'h10);
    rst = 1'b1;
    #1;
    checks++; if ({flush, redirect_valid, flags} !== 6'b0) begin errors++; $display("FAIL midrst_outputs: got flush %b rv %b flags %b exp 0 0 0000", flush, redirect_valid, flags); end
    cyc();
    rst = 1'b0;
    cyc();
    m_flags = 4'h0; m_fv = 1'b0;
    checks++; if ({br_ready, flush} !== 2'b10) begin errors++; $display("FAIL midrst_ready: got ready/flush %b exp 10", {br_ready, flush}); end
    issue(3'd0, 32'h600, 32'h10);
    checks++; if ({br_ready, redirect_valid} !== 2'b00) begin errors++; $display("FAIL midrst_flags_invalid: got ready/rv %b exp 00", {br_ready, redirect_valid}); end
    rst = 1'b1;
    #1;
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    logic [3:0] wf, wf2, res_fl;
    logic [2:0] f3;
    logic [31:0] pc, off, tgt;
    bit same, avail, illegal, got, done;
    int wk, resolve_j;
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        write_flags(4'($urandom));
        checks++; if (flags !== m_flags) begin errors++; $display("FAIL rnd_write_flags: got %b exp %b", flags, m_flags); end
      end
      f3 = 3'($urandom_range(0, 7)); pc = $urandom; off = $urandom;
      same = ($urandom_range(0, 3) == 0); wf = 4'($urandom); wf2 = 4'($urandom);
      tgt = (pc + off) & 32'hFFFF_FFFE;
      illegal = (f3 == 3'd2) || (f3 == 3'd3);
      checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL rnd_ready_in: got %b exp 1", br_ready); end
      csr_write = same; csr_in = wf;
      issue(f3, pc, off);
      csr_write = 1'b0;
      avail = m_fv || (BYPASS && same);
      res_fl = (BYPASS && same) ? wf : m_flags;
      if (same) m_flags = wf;
      if (illegal) m_fv = m_fv || same;
      else if (avail) m_fv = same && !BYPASS;
      else m_fv = same;
      checks++; if (flags !== m_flags) begin errors++; $display("FAIL rnd_flags: got %b exp %b", flags, m_flags); end
      got = illegal || avail;
      if (!got) begin
        wk = same ? 0 : (($urandom_range(0, 5) == 0) ? 99 : $urandom_range(1, 4));
        resolve_j = BYPASS ? wk : wk + 1;
        done = 1'b0;
        for (int j = 1; j <= WM && !done; j++) begin
          if (j == wk) begin csr_write = 1'b1; csr_in = wf2; end
          cyc();
          csr_write = 1'b0;
          if (j == wk) begin m_flags = wf2; m_fv = 1'b1; end
          if (j == resolve_j) begin
            got = 1'b1; done = 1'b1; res_fl = m_flags; m_fv = 1'b0;
          end else if (j == WM) begin
            done = 1'b1;
            checks++; if ({br_timeout, br_ready, redirect_valid} !== 3'b110) begin errors++; $display("FAIL rnd_timeout: got to/ready/rv %b exp 110", {br_timeout, br_ready, redirect_valid}); end
          end else begin
            checks++; if ({br_timeout, br_ready, redirect_valid} !== 3'b000) begin errors++; $display("FAIL rnd_waiting j=%0d: got to/ready/rv %b exp 000", j, {br_timeout, br_ready, redirect_valid}); end
          end
        end
      end
      if (got) begin
        if (illegal) begin
          checks++; if ({br_illegal, redirect_valid, flush, br_ready} !== 4'b1001) begin errors++; $display("FAIL rnd_illegal f3=%0d: got ill/rv/flush/ready %b exp 1001", f3, {br_illegal, redirect_valid, flush, br_ready}); end
        end else if (exp_taken(f3, res_fl)) begin
          checks++; if ({redirect_valid, flush, br_ready, redirect_pc} !== {3'b110, tgt}) begin errors++; $display("FAIL rnd_taken f3=%0d fl=%b: got rv/flush/ready %b pc %h exp 110 pc %h", f3, res_fl, {redirect_valid, flush, br_ready}, redirect_pc, tgt); end
          for (int c = 2; c <= FC; c++) begin
            cyc();
            checks++; if ({redirect_valid, flush, br_ready} !== 3'b010) begin errors++; $display("FAIL rnd_flush_hold: got rv/flush/ready %b exp 010", {redirect_valid, flush, br_ready}); end
          end
          cyc();
          checks++; if ({flush, br_ready} !== 2'b01) begin errors++; $display("FAIL rnd_flush_end: got flush/ready %b exp 01", {flush, br_ready}); end
        end else begin
          checks++; if ({br_illegal, redirect_valid, flush, br_ready} !== 4'b0001) begin errors++; $display("FAIL rnd_not_taken f3=%0d fl=%b: got ill/rv/flush/ready %b exp 0001", f3, res_fl, {br_illegal, redirect_valid, flush, br_ready}); end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_blt_bgeu_wait();
    test_timeout();
    test_illegal();
    test_wrap();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
